// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Op encodings, FSM state encoding and slice width for the
//               ALU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int c_slice_w = 4;

    localparam logic [1:0] c_op_and8 = 2'b00;
    localparam logic [1:0] c_op_add8 = 2'b01;
    localparam logic [1:0] c_op_mul4 = 2'b10;
    localparam logic [1:0] c_op_rsvd = 2'b11;

    localparam int c_state_w = 3;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle = 3'd0;
    localparam state_t c_st_lo   = 3'd1;
    localparam state_t c_st_hi   = 3'd2;
    localparam state_t c_st_mul  = 3'd3;
    localparam state_t c_st_done = 3'd4;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Drives an external 4-bit AND/ADD ALU over several cycles to
//               perform 8-bit AND/ADD and 4x4 shift-add multiply requests.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SLICE_W = c_slice_w
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [2*SLICE_W-1:0]   opa,
    input  logic [2*SLICE_W-1:0]   opb,
    output logic                   busy,
    output logic                   done,
    output logic [2*SLICE_W-1:0]   res,
    output logic                   cout,
    output logic                   err,
    output logic [SLICE_W-1:0]     alu_a,
    output logic [SLICE_W-1:0]     alu_b,
    output logic                   alu_sel,
    output logic                   alu_c_in,
    input  logic [SLICE_W-1:0]     alu_result,
    input  logic                   alu_c_out
);

    if (SLICE_W != 4) begin : g_slice_w_check
        $error("alu_op_sequencer: only SLICE_W=4 is supported");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_op;
    logic [2*SLICE_W-1:0]   r_opa;
    logic [2*SLICE_W-1:0]   r_opb;
    logic [2*SLICE_W-1:0]   r_p;
    logic [1:0]             r_cnt;
    logic                   r_carry;
    logic [2*SLICE_W-1:0]   r_res;
    logic                   r_cout;
    logic                   r_err;

    logic [SLICE_W-1:0]     w_alu_a;
    logic [SLICE_W-1:0]     w_alu_b;
    logic                   w_alu_sel;
    logic                   w_alu_c_in;
    logic [2*SLICE_W-1:0]   w_p_nxt;

    // Shift-add step: the ALU sum becomes the new upper half, shifted right.
    assign w_p_nxt = {alu_c_out, alu_result, r_p[SLICE_W-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_alu_a     = '0;
        w_alu_b     = '0;
        w_alu_sel   = 1'b0;
        w_alu_c_in  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    case (op)
                        c_op_rsvd: w_state_nxt = c_st_done;
                        c_op_mul4: w_state_nxt = c_st_mul;
                        default:   w_state_nxt = c_st_lo;
                    endcase
                end
            end
            c_st_lo: begin
                w_alu_a     = r_opa[SLICE_W-1:0];
                w_alu_b     = r_opb[SLICE_W-1:0];
                w_alu_sel   = r_op[0];
                w_state_nxt = c_st_hi;
            end
            c_st_hi: begin
                w_alu_a     = r_opa[2*SLICE_W-1:SLICE_W];
                w_alu_b     = r_opb[2*SLICE_W-1:SLICE_W];
                w_alu_sel   = r_op[0];
                w_alu_c_in  = r_carry;
                w_state_nxt = c_st_done;
            end
            c_st_mul: begin
                w_alu_a   = r_p[2*SLICE_W-1:SLICE_W];
                w_alu_b   = r_p[0] ? r_opa[SLICE_W-1:0] : '0;
                w_alu_sel = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_op    <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_op    <= op;
                        r_opa   <= opa;
                        r_opb   <= opb;
                        r_p     <= {{SLICE_W{1'b0}}, opb[SLICE_W-1:0]};
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_res   <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= (op == c_op_rsvd);
                    end
                end
                c_st_lo: begin
                    r_res[SLICE_W-1:0] <= alu_result;
                    r_carry            <= (r_op == c_op_add8) & alu_c_out;
                end
                c_st_hi: begin
                    r_res[2*SLICE_W-1:SLICE_W] <= alu_result;
                    r_cout                     <= (r_op == c_op_add8) & alu_c_out;
                end
                c_st_mul: begin
                    r_p   <= w_p_nxt;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_res <= w_p_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != c_st_idle);
    assign done     = (r_state == c_st_done);
    assign res      = r_res;
    assign cout     = r_cout;
    assign err      = r_err;
    assign alu_a    = w_alu_a;
    assign alu_b    = w_alu_b;
    assign alu_sel  = w_alu_sel;
    assign alu_c_in = w_alu_c_in;

endmodule
`default_nettype wire
